// File: rtl/branch_fwd_scoreboard.sv
// Branch-operand hazard unit: MEM/WB forwarding select for the ID-stage branch comparator,
// plus a small scoreboard of in-flight fixed-latency multiplies that stalls dependent branches.
module branch_fwd_scoreboard #(
   parameter int unsigned DATA_WIDTH = 5,
   parameter int unsigned NUM_SLOTS  = 4,
   parameter int unsigned MUL_LAT    = 3
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [DATA_WIDTH-1:0]            Rs1,
   input  logic [DATA_WIDTH-1:0]            Rs2,
   input  logic                             Branch,
   input  logic                             Issue_Mul,
   input  logic [DATA_WIDTH-1:0]            Issue_Rd,
   input  logic                             M_RegWrite,
   input  logic [DATA_WIDTH-1:0]            M_Rd,
   input  logic                             W_RegWrite,
   input  logic [DATA_WIDTH-1:0]            W_Rd,
   input  logic                             Flush,
   output logic [1:0]                       B_AForward,
   output logic [1:0]                       B_BForward,
   output logic                             Branch_Stall,
   output logic                             Mul_Full,
   output logic [$clog2(NUM_SLOTS+1)-1:0]   Pending,
   output logic                             Overflow_Err
);

   localparam int unsigned CntW  = $clog2(MUL_LAT + 1);
   localparam int unsigned PendW = $clog2(NUM_SLOTS + 1);

   logic [NUM_SLOTS-1:0]                 valid_q, valid_d;
   logic [DATA_WIDTH-1:0]                rd_q    [NUM_SLOTS];
   logic [DATA_WIDTH-1:0]                rd_d    [NUM_SLOTS];
   logic [CntW-1:0]                      cnt_q   [NUM_SLOTS];
   logic [CntW-1:0]                      cnt_d   [NUM_SLOTS];
   logic                                 overflow_q, overflow_d;

   logic [NUM_SLOTS-1:0]                 busy;
   logic [NUM_SLOTS-1:0]                 alloc_sel;
   logic                                 alloc;
   logic                                 hit_a, hit_b;
   logic                                 use_a, use_b;
   logic [PendW-1:0]                     pend;

   // A slot is busy while its result has not yet reached WB; a slot at cnt==1 is reusable.
   always_comb begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
         busy[i] = valid_q[i] && (cnt_q[i] > CntW'(1));
      end
   end

   assign Mul_Full = &busy;
   assign alloc    = Issue_Mul && (Issue_Rd != '0) && !Mul_Full && !Flush;

   // Lowest-index free slot, one-hot.
   always_comb begin
      logic found;
      found     = 1'b0;
      alloc_sel = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (!busy[i] && !found) begin
            alloc_sel[i] = 1'b1;
            found        = 1'b1;
         end
      end
   end

   always_comb begin
      valid_d    = valid_q;
      overflow_d = overflow_q;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         rd_d[i]  = rd_q[i];
         cnt_d[i] = cnt_q[i];
         if (valid_q[i]) begin
            if (cnt_q[i] == CntW'(1)) begin
               valid_d[i] = 1'b0;
               cnt_d[i]   = '0;
            end else begin
               cnt_d[i] = cnt_q[i] - CntW'(1);
            end
         end
         if (alloc && alloc_sel[i]) begin
            valid_d[i] = 1'b1;
            rd_d[i]    = Issue_Rd;
            cnt_d[i]   = CntW'(MUL_LAT);
         end
         if (Flush) begin
            valid_d[i] = 1'b0;
            cnt_d[i]   = '0;
         end
      end
      if (Issue_Mul && (Issue_Rd != '0) && Mul_Full) begin
         overflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q    <= '0;
         overflow_q <= 1'b0;
         for (int i = 0; i < NUM_SLOTS; i++) begin
            rd_q[i]  <= '0;
            cnt_q[i] <= '0;
         end
      end else begin
         valid_q    <= valid_d;
         overflow_q <= overflow_d;
         for (int i = 0; i < NUM_SLOTS; i++) begin
            rd_q[i]  <= rd_d[i];
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign Overflow_Err = overflow_q;

   always_comb begin
      pend = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         pend = pend + PendW'(valid_q[i]);
      end
   end

   assign Pending = pend;

   always_comb begin
      hit_a = 1'b0;
      hit_b = 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (busy[i] && (rd_q[i] == Rs1)) hit_a = 1'b1;
         if (busy[i] && (rd_q[i] == Rs2)) hit_b = 1'b1;
      end
   end

   assign use_a = Branch && (Rs1 != '0);
   assign use_b = Branch && (Rs2 != '0);

   // A stalled operand keeps forward=00; its value is re-selected once the multiply lands.
   always_comb begin
      B_AForward = 2'b00;
      B_BForward = 2'b00;
      if (use_a && !hit_a) begin
         if (M_RegWrite && (M_Rd == Rs1))      B_AForward = 2'b01;
         else if (W_RegWrite && (W_Rd == Rs1)) B_AForward = 2'b10;
      end
      if (use_b && !hit_b) begin
         if (M_RegWrite && (M_Rd == Rs2))      B_BForward = 2'b01;
         else if (W_RegWrite && (W_Rd == Rs2)) B_BForward = 2'b10;
      end
   end

   assign Branch_Stall = (use_a && hit_a) || (use_b && hit_b);

endmodule

// File: tb/tb_branch_fwd_scoreboard.sv
// Directed bench for branch_fwd_scoreboard; one instance at MUL_LAT=3, one at MUL_LAT=8,
// both driven by the same stimulus.
module tb_branch_fwd_scoreboard;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] Rs1, Rs2, Issue_Rd, M_Rd, W_Rd;
   logic       Branch, Issue_Mul, M_RegWrite, W_RegWrite, Flush;

   logic [1:0] a3_fwd, b3_fwd, a8_fwd, b8_fwd;
   logic       stall3, full3, ovf3, stall8, full8, ovf8;
   logic [2:0] pend3, pend8;

   int n_checks = 0;
   int n_fails  = 0;

   always #5 clk = ~clk;

   branch_fwd_scoreboard #(.DATA_WIDTH(5), .NUM_SLOTS(4), .MUL_LAT(3)) d3 (
      .clk(clk), .rst_n(rst_n), .Rs1(Rs1), .Rs2(Rs2), .Branch(Branch),
      .Issue_Mul(Issue_Mul), .Issue_Rd(Issue_Rd), .M_RegWrite(M_RegWrite), .M_Rd(M_Rd),
      .W_RegWrite(W_RegWrite), .W_Rd(W_Rd), .Flush(Flush),
      .B_AForward(a3_fwd), .B_BForward(b3_fwd), .Branch_Stall(stall3),
      .Mul_Full(full3), .Pending(pend3), .Overflow_Err(ovf3)
   );

   branch_fwd_scoreboard #(.DATA_WIDTH(5), .NUM_SLOTS(4), .MUL_LAT(8)) d8 (
      .clk(clk), .rst_n(rst_n), .Rs1(Rs1), .Rs2(Rs2), .Branch(Branch),
      .Issue_Mul(Issue_Mul), .Issue_Rd(Issue_Rd), .M_RegWrite(M_RegWrite), .M_Rd(M_Rd),
      .W_RegWrite(W_RegWrite), .W_Rd(W_Rd), .Flush(Flush),
      .B_AForward(a8_fwd), .B_BForward(b8_fwd), .Branch_Stall(stall8),
      .Mul_Full(full8), .Pending(pend8), .Overflow_Err(ovf8)
   );

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; inputs and checks happen mid-cycle.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic clear_inputs();
      Rs1 = '0; Rs2 = '0; Branch = 0; Issue_Mul = 0; Issue_Rd = '0;
      M_RegWrite = 0; M_Rd = '0; W_RegWrite = 0; W_Rd = '0; Flush = 0;
   endtask

   task automatic reset_pulse();
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      clear_inputs();
      rst_n = 1'b0;
      #12;
      check("rst_pend8", 8'(pend8), 8'd0);
      check("rst_full8", 8'(full8), 8'd0);
      check("rst_ovf8", 8'(ovf8), 8'd0);
      check("rst_stall3", 8'(stall3), 8'd0);
      check("rst_full3", 8'(full3), 8'd0);
      check("rst_ovf3", 8'(ovf3), 8'd0);
      check("rst_pend3", 8'(pend3), 8'd0);
      rst_n = 1'b1;

      // Plain MEM/WB forwarding
      Branch = 1; Rs1 = 5; Rs2 = 6; M_RegWrite = 1; M_Rd = 5; W_RegWrite = 1; W_Rd = 6;
      #1;
      check("t1_afwd", 8'(a3_fwd), 8'd1);
      check("t1_bfwd", 8'(b3_fwd), 8'd2);
      check("t1_stall", 8'(stall3), 8'd0);
      W_Rd = 5;
      #1;
      check("t1_mem_beats_wb", 8'(a3_fwd), 8'd1);
      check("t1_b_none", 8'(b3_fwd), 8'd0);
      Branch = 0;
      #1;
      check("t1_nobranch", 8'(a8_fwd), 8'd0);
      clear_inputs();

      // Multiply latency 3 stall window
      tick();
      Issue_Mul = 1; Issue_Rd = 7;
      tick();
      Issue_Mul = 0; Branch = 1; Rs1 = 7; W_RegWrite = 1; W_Rd = 7;
      #1;
      check("t2_stall_c1", 8'(stall3), 8'd1);
      check("t2_afwd_c1", 8'(a3_fwd), 8'd0);
      check("t2_pend_c1", 8'(pend3), 8'd1);
      tick();
      check("t2_stall_c2", 8'(stall3), 8'd1);
      tick();
      check("t2_stall_c3", 8'(stall3), 8'd0);
      check("t2_afwd_c3", 8'(a3_fwd), 8'd2);
      check("t2_pend_c3", 8'(pend3), 8'd1);
      tick();
      check("t2_pend_c4", 8'(pend3), 8'd0);
      clear_inputs();
      reset_pulse();

      // Fill all four slots, then overflow
      Issue_Mul = 1;
      for (int r = 1; r <= 4; r++) begin
         Issue_Rd = 5'(r);
         tick();
      end
      check("t3_full", 8'(full8), 8'd1);
      check("t3_pend", 8'(pend8), 8'd4);
      Issue_Rd = 5;
      #1;
      check("t3_ovf_before", 8'(ovf8), 8'd0);
      tick();
      check("t3_ovf_set", 8'(ovf8), 8'd1);
      check("t3_pend_after", 8'(pend8), 8'd4);
      Issue_Mul = 0;
      tick();
      check("t3_ovf_sticky", 8'(ovf8), 8'd1);
      clear_inputs();
      reset_pulse();

      // Same-edge free and reuse of slot 0
      Issue_Mul = 1;
      for (int r = 1; r <= 4; r++) begin
         Issue_Rd = 5'(r);
         tick();
      end
      Issue_Mul = 0;
      for (int k = 0; k < 4; k++) tick();
      Branch = 1; Rs1 = 1; W_RegWrite = 1; W_Rd = 1;
      #1;
      check("t4_full_cnt1", 8'(full8), 8'd0);
      check("t4_nostall_cnt1", 8'(stall8), 8'd0);
      check("t4_fwd_wb", 8'(a8_fwd), 8'd2);
      Issue_Mul = 1; Issue_Rd = 9;
      tick();
      Issue_Mul = 0; Rs1 = 9; W_RegWrite = 0;
      #1;
      check("t4_pend", 8'(pend8), 8'd4);
      check("t4_noovf", 8'(ovf8), 8'd0);
      check("t4_stall_rd9", 8'(stall8), 8'd1);
      Rs1 = 1;
      #1;
      check("t4_rd1_gone", 8'(stall8), 8'd0);
      clear_inputs();
      reset_pulse();

      // Flush with a same-cycle issue
      Issue_Mul = 1; Issue_Rd = 3;
      tick();
      Issue_Rd = 4;
      tick();
      check("t5_pend2", 8'(pend8), 8'd2);
      Flush = 1; Issue_Rd = 3;
      tick();
      Flush = 0; Issue_Mul = 0; Branch = 1; Rs1 = 3;
      #1;
      check("t5_pend0", 8'(pend8), 8'd0);
      check("t5_nostall", 8'(stall8), 8'd0);
      clear_inputs();

      // Register zero and mid-count asynchronous reset
      Branch = 1; Rs1 = 0; W_RegWrite = 1; W_Rd = 0; Issue_Mul = 1; Issue_Rd = 0;
      #1;
      check("t6_x0_fwd", 8'(a8_fwd), 8'd0);
      check("t6_x0_stall", 8'(stall8), 8'd0);
      tick();
      check("t6_rd0_pend", 8'(pend8), 8'd0);
      check("t6_rd0_ovf", 8'(ovf8), 8'd0);
      clear_inputs();
      Issue_Mul = 1; Issue_Rd = 7;
      tick();
      Issue_Mul = 0; Branch = 1; Rs1 = 7;
      #1;
      check("t6_pre_stall", 8'(stall8), 8'd1);
      check("t6_pre_pend", 8'(pend8), 8'd1);
      rst_n = 1'b0;
      #1;
      check("t6_rst_pend", 8'(pend8), 8'd0);
      check("t6_rst_stall", 8'(stall8), 8'd0);
      check("t6_rst_full", 8'(full8), 8'd0);
      check("t6_rst_fwd", 8'(a8_fwd), 8'd0);
      check("t6_rst_stall3", 8'(stall3), 8'd0);
      rst_n = 1'b1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
